sd_card_pll_reset_seq: RTL and testbench
========================================

# sd_card_pll_reset_seq

Reset and lock sequencer for the 50→100 MHz system PLL in the SD card design. Drives the PLL reset, qualifies its `locked` output, and releases the system reset only after a stable lock. Retries on lock timeout, recovers from lock loss, and reports a fault when the retry budget is exhausted. Runs entirely in the `refclk` domain; consumers in the 100 MHz domain resynchronize `sys_rst` locally.

## Interface
- `RST_PULSE_CYCLES`, 16: PLL reset pulse width in refclk cycles, ≥2
- `LOCK_TIMEOUT_CYCLES`, 50000: maximum time in WAIT_LOCK per attempt (1 ms at 50 MHz), ≥1
- `LOCK_STABLE_CYCLES`, 256: consecutive synchronized-lock cycles required before release, ≥1
- `MAX_RETRIES`, 3: retries after the first attempt before FAULT, 0..15

- `refclk`  in  1  the block's single clock, 50 MHz
- `rst`  in  1  synchronous, active-high reset
- `pll_locked`  in  1  PLL lock, asynchronous to `refclk`
- `restart`  in  1  single-cycle request to restart the sequence from any state
- `pll_rst`  out  1  reset to the PLL
- `sys_rst`  out  1  active-high system reset for downstream logic
- `ready`  out  1  PLL locked and stable, system released
- `fault`  out  1  retry budget exhausted
- `lock_lost`  out  1  one-cycle pulse when lock drops in RUN
- `retry_count`  out  4  retries consumed in the current sequence

## Operation
- `pll_locked` passes through a 2-flop synchronizer (reset to 0) to give `lock_s`. All outputs are registered or decoded from registers, with no combinational path from inputs.
- Priority: `rst` > `restart` > FSM transitions.
- States:
  - RESET_PLL: `pll_rst`=1. Occupies exactly RST_PULSE_CYCLES cycles, then goes to WAIT_LOCK with the counter cleared.
  - WAIT_LOCK: `pll_rst`=0.
    - `lock_s`=1 → STABLE, counter cleared.
    - After LOCK_TIMEOUT_CYCLES cycles without lock, if `retry_count`<MAX_RETRIES: increment `retry_count` and go to RESET_PLL. Otherwise go to FAULT.
  - STABLE: counts consecutive cycles with `lock_s`=1.
    - `lock_s`=0 → WAIT_LOCK, counter cleared. This does not consume a retry.
    - After LOCK_STABLE_CYCLES cycles → RUN.
  - RUN: `sys_rst`=0, `ready`=1. `lock_s`=0 → RESET_PLL, with `lock_lost`=1 for one cycle and `retry_count` cleared to 0.
  - FAULT: `pll_rst`=1, `fault`=1. Exits only on `rst` or `restart`.
- `sys_rst`=1 and `ready`=0 in every state except RUN.
- `restart`, in any state, goes to RESET_PLL. It clears `retry_count`, the counter and `fault`. In RUN it does not pulse `lock_lost`.
- Counter is 17 bits minimum and saturation-free; it is cleared on every state entry.

## Timing
- Reset values while `rst`=1: state RESET_PLL, counter 0, `pll_rst`=1, `sys_rst`=1, `ready`=0, `fault`=0, `lock_lost`=0, `retry_count`=0, synchronizer 0.
- Cycle 1 is the first cycle with `rst`=0. With `pll_locked` held at 1, `ready` first goes high in cycle RST_PULSE_CYCLES+1+LOCK_STABLE_CYCLES, which is 273 with default parameters.
- Lock-loss latency: a `pll_locked` fall sampled at edge k sets `sys_rst`=1, `ready`=0 and `lock_lost`=1 after edge k+2.
- `restart` sampled at edge k: `pll_rst`=1 after edge k. The reset pulse then lasts exactly RST_PULSE_CYCLES cycles.
- `rst` asserted mid-sequence forces the reset values on the next edge, regardless of state.
- A `pll_locked` glitch shorter than one `refclk` period during STABLE is either missed or restarts STABLE. It never reaches RUN early.

## Test plan
- Defaults, `pll_locked`=1 constant, `rst` released → `pll_rst` high in cycles 1–16 and low from cycle 17; `ready`=1 and `sys_rst`=0 from cycle 273; `retry_count`=0.
- LOCK_TIMEOUT_CYCLES=100, MAX_RETRIES=2, `pll_locked`=0 → exactly 3 `pll_rst` pulses of 16 cycles each; `retry_count` goes 1 then 2; `fault`=1 from cycle 349 with `pll_rst` held high. Then `restart` → `fault`=0, `retry_count`=0, new pulse.
- In RUN, drop `pll_locked` for 5 cycles → one-cycle `lock_lost`; `sys_rst` high 3 edges after the drop; new 16-cycle `pll_rst`; `ready` returns after lock and 256 stable cycles.
- Defaults, `pll_locked` drops once at cycle 100 of STABLE → state returns to WAIT_LOCK; `retry_count` unchanged; `ready` rises 256 cycles after lock returns.
- `rst` asserted during STABLE, and separately during FAULT → all outputs at reset values after the next edge; the sequence restarts cleanly.
- `restart` and `rst` asserted in the same cycle → reset values are applied, with `rst` taking priority.

Source files
------------

// File: rtl/sd_card_pll_reset_seq.sv
// sd_card_pll_reset_seq
// Reset and lock sequencer for the 50->100 MHz system PLL. Pulses the PLL
// reset, qualifies the synchronized lock, and releases the system reset only
// after a stable lock. Retries on lock timeout, recovers from lock loss and
// flags a fault once the retry budget is exhausted. Single refclk domain.
//
// Ports
//   refclk_i        reference clock (50 MHz)
//   rst_i           synchronous active-high reset
//   pll_locked_i    PLL lock, asynchronous to refclk_i
//   restart_i       single-cycle request to restart the sequence
//   pll_rst_o       reset to the PLL
//   sys_rst_o       active-high reset for downstream logic
//   ready_o         PLL locked and stable, system released
//   fault_o         retry budget exhausted
//   lock_lost_o     one-cycle pulse when lock drops while running
//   retry_count_o   retries consumed in the current sequence
//
// state      | meaning
// -----------+-----------------------------------------------------------
// RESET_PLL  | PLL held in reset for RST_PULSE_CYCLES cycles
// WAIT_LOCK  | PLL released, waiting for lock or timeout
// STABLE     | lock seen, counting consecutive locked cycles
// RUN        | system released, watching for lock loss
// FAULT      | retries exhausted, PLL held in reset until rst/restart

module sd_card_pll_reset_seq #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 256,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       refclk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       restart_i,
  output logic       pll_rst_o,
  output logic       sys_rst_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic       lock_lost_o,
  output logic [3:0] retry_count_o
);

  localparam int unsigned MAX_A   = (LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES) ?
                                    LOCK_TIMEOUT_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > RST_PULSE_CYCLES) ? MAX_A : RST_PULSE_CYCLES;
  localparam int unsigned CNT_RAW = $clog2(MAX_CYC + 1);
  localparam int unsigned CNT_W   = (CNT_RAW > 17) ? CNT_RAW : 17;

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  // The WAIT_LOCK cycle that sees lock is the first of the stable run, so
  // STABLE itself only has to cover the remaining LOCK_STABLE_CYCLES-1.
  localparam logic [CNT_W-1:0] STABLE_LAST  = (LOCK_STABLE_CYCLES >= 2) ?
                                              CNT_W'(LOCK_STABLE_CYCLES - 2) : '0;
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET_PLL,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             lost_q, lost_d;
  logic             sync1_q, lock_s_q;

  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      state_q  <= ST_RESET_PLL;
      cnt_q    <= '0;
      retry_q  <= '0;
      lost_q   <= 1'b0;
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      lost_q   <= lost_d;
      sync1_q  <= pll_locked_i;
      lock_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    lost_d  = 1'b0;

    if (restart_i) begin
      state_d = ST_RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RESET_PLL: begin
          if (cnt_q == PULSE_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = (LOCK_STABLE_CYCLES == 1) ? ST_RUN : ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 4'd1;
              state_d = ST_RESET_PLL;
            end else begin
              state_d = ST_FAULT;
            end
          end
        end
        ST_STABLE: begin
          // A lock drop here is a glitch, not a failed attempt: no retry used.
          if (!lock_s_q) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        ST_RUN: begin
          cnt_d = cnt_q;
          if (!lock_s_q) begin
            state_d = ST_RESET_PLL;
            cnt_d   = '0;
            retry_d = '0;
            lost_d  = 1'b1;
          end
        end
        ST_FAULT: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign pll_rst_o     = (state_q == ST_RESET_PLL) || (state_q == ST_FAULT);
  assign sys_rst_o     = (state_q != ST_RUN);
  assign ready_o       = (state_q == ST_RUN);
  assign fault_o       = (state_q == ST_FAULT);
  assign lock_lost_o   = lost_q;
  assign retry_count_o = retry_q;

endmodule

// File: tb/tb_sd_card_pll_reset_seq.sv
// tb_sd_card_pll_reset_seq
// Directed scenarios for the PLL reset sequencer plus a randomized lock /
// restart / reset phase, all compared against a behavioural model that
// tracks attempts as pulse, acquire (wait + stable run length), run, fault.

module tb_sd_card_pll_reset_seq;

  localparam int PULSE = 16;
  localparam int TMO   = 100;
  localparam int STAB  = 256;
  localparam int RETR  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b1;
  logic       restart = 1'b0;
  logic       pll_rst, sys_rst, ready, fault, lock_lost;
  logic [3:0] retry_count;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  sd_card_pll_reset_seq #(
    .RST_PULSE_CYCLES   (PULSE),
    .LOCK_TIMEOUT_CYCLES(TMO),
    .LOCK_STABLE_CYCLES (STAB),
    .MAX_RETRIES        (RETR)
  ) dut (
    .refclk_i     (clk),
    .rst_i        (rst),
    .pll_locked_i (pll_locked),
    .restart_i    (restart),
    .pll_rst_o    (pll_rst),
    .sys_rst_o    (sys_rst),
    .ready_o      (ready),
    .fault_o      (fault),
    .lock_lost_o  (lock_lost),
    .retry_count_o(retry_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: an attempt is a reset pulse followed by an acquire
  // phase. During acquire, the run length of synchronized lock decides
  // release; cycles without lock (outside a run) count toward timeout.
  typedef enum int {M_PULSE, M_ACQ, M_RUN, M_FAULT} ph_t;
  ph_t m_ph = M_PULSE;
  int  m_left = PULSE;
  int  m_wait = 0;
  int  m_run  = 0;
  int  m_retries = 0;
  bit  m_lost = 1'b0;
  bit  m_d1 = 1'b0;
  bit  m_d2 = 1'b0;

  always @(posedge clk) begin : model
    bit ls;
    if (rst) begin
      m_ph = M_PULSE; m_left = PULSE; m_wait = 0; m_run = 0;
      m_retries = 0; m_lost = 1'b0; m_d1 = 1'b0; m_d2 = 1'b0;
    end else begin
      ls = m_d2;
      m_d2 = m_d1;
      m_d1 = pll_locked;
      m_lost = 1'b0;
      if (restart) begin
        m_ph = M_PULSE; m_left = PULSE; m_retries = 0;
      end else begin
        case (m_ph)
          M_PULSE: begin
            m_left--;
            if (m_left == 0) begin m_ph = M_ACQ; m_wait = 0; m_run = 0; end
          end
          M_ACQ: begin
            if (ls) begin
              m_run++;
              if (m_run == STAB) m_ph = M_RUN;
            end else if (m_run > 0) begin
              m_run = 0; m_wait = 0;
            end else begin
              m_wait++;
              if (m_wait == TMO) begin
                if (m_retries < RETR) begin
                  m_retries++; m_ph = M_PULSE; m_left = PULSE;
                end else begin
                  m_ph = M_FAULT;
                end
              end
            end
          end
          M_RUN: begin
            if (!ls) begin
              m_lost = 1'b1; m_retries = 0; m_ph = M_PULSE; m_left = PULSE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("m_pll_rst",   pll_rst,     (m_ph == M_PULSE) || (m_ph == M_FAULT));
      chk("m_sys_rst",   sys_rst,     m_ph != M_RUN);
      chk("m_ready",     ready,       m_ph == M_RUN);
      chk("m_fault",     fault,       m_ph == M_FAULT);
      chk("m_lock_lost", lock_lost,   m_lost);
      chk("m_retry",     retry_count, m_retries);
    end
  end

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return ready;
      1:       return pll_rst;
      default: return fault;
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int which, input logic val,
                          input int bound, output int n);
    n = 0;
    while (sel(which) !== val && n < bound) begin
      step();
      n++;
    end
    chk(tag, sel(which), val);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"},   pll_rst,     1);
    chk({tag, "_sys_rst"},   sys_rst,     1);
    chk({tag, "_ready"},     ready,       0);
    chk({tag, "_fault"},     fault,       0);
    chk({tag, "_lock_lost"}, lock_lost,   0);
    chk({tag, "_retry"},     retry_count, 0);
  endtask

  // Called at the negedge that is cycle 1 (rst was high at the last edge),
  // with pll_locked held at 1.
  task automatic measure_release(input string tag);
    int first_low;
    int first_ready;
    first_low = 0;
    first_ready = 0;
    while (cyc <= 300) begin
      if (!pll_rst && first_low == 0) first_low = cyc;
      if (ready && first_ready == 0) first_ready = cyc;
      if (first_ready != 0) break;
      step();
    end
    chk({tag, "_first_prst_low"}, first_low, PULSE + 1);
    chk({tag, "_first_ready"},    first_ready, PULSE + 1 + STAB);
    chk({tag, "_sys_rst_run"},    sys_rst, 0);
    chk({tag, "_retry_run"},      retry_count, 0);
  endtask

  initial begin
    int n, i, run_len, n_pulses, n_ok, first_fault;
    int first_sys, n_lost, rst_len, fall_at, ready_at, len;
    bit saw_prst;
    int total;

    // T1: nominal bring-up with lock held high
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    rst = 1'b0;
    cyc = 1;
    chk_reset_vals("t1_c1");
    measure_release("t1");

    // T2: no lock -> three pulses, then fault; restart clears it
    rst = 1'b1; pll_locked = 1'b0;
    step();
    rst = 1'b0; cyc = 1;
    run_len = 0; n_pulses = 0; n_ok = 0; first_fault = 0;
    while (cyc <= 360) begin
      if (pll_rst) run_len++;
      else begin
        if (run_len > 0) begin
          n_pulses++;
          if (run_len == PULSE) n_ok++;
        end
        run_len = 0;
      end
      if (fault && first_fault == 0) first_fault = cyc;
      if (cyc == 120) chk("t2_retry_c120", retry_count, 1);
      if (cyc == 240) chk("t2_retry_c240", retry_count, 2);
      step();
    end
    chk("t2_pulses",      n_pulses, 3);
    chk("t2_pulses_16",   n_ok, 3);
    chk("t2_first_fault", first_fault, 349);
    chk("t2_fault_prst",  pll_rst, 1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("t2_rs_fault", fault, 0);
    chk("t2_rs_retry", retry_count, 0);
    len = 0;
    while (pll_rst && len < 40) begin
      len++;
      step();
    end
    chk("t2_rs_pulse_len", len, PULSE);

    // T3: lock loss in RUN for 5 cycles
    pll_locked = 1'b1; restart = 1'b1;
    step();
    restart = 1'b0;
    wait_sig("t3_reach_run", 0, 1'b1, 400, n);
    repeat (5) step();
    pll_locked = 1'b0;
    i = 0; first_sys = 0; n_lost = 0; rst_len = 0; fall_at = 0; ready_at = 0;
    while (i < 400 && ready_at == 0) begin
      if (i == 5) pll_locked = 1'b1;
      if (i > 0) begin
        if (sys_rst && first_sys == 0) first_sys = i;
        if (lock_lost) n_lost++;
        if (pll_rst) rst_len++;
        if (rst_len > 0 && !pll_rst && fall_at == 0) fall_at = i;
        if (fall_at != 0 && ready && ready_at == 0) ready_at = i;
      end
      step();
      i++;
    end
    chk("t3_sys_rst_delay", first_sys, 3);
    chk("t3_lock_lost_cnt", n_lost, 1);
    chk("t3_prst_len",      rst_len, PULSE);
    chk("t3_ready_seen",    ready_at != 0, 1);
    chk("t3_ready_delay",   ready_at - fall_at, STAB);

    // T4: single-cycle lock glitch at STABLE cycle 100
    restart = 1'b1;
    step();
    restart = 1'b0;
    wait_sig("t4_wait_lock", 1, 1'b0, 40, n);
    repeat (100) step();
    pll_locked = 1'b0;
    n = 0; saw_prst = 1'b0;
    while (n < 400 && !ready) begin
      step();
      n++;
      if (n == 1) pll_locked = 1'b1;
      if (pll_rst) saw_prst = 1'b1;
    end
    chk("t4_ready_delay", n, 3 + STAB);
    chk("t4_no_prst",     saw_prst, 0);
    chk("t4_retry",       retry_count, 0);

    // T5a: rst during STABLE
    restart = 1'b1;
    step();
    restart = 1'b0;
    wait_sig("t5a_wait_lock", 1, 1'b0, 40, n);
    repeat (50) step();
    rst = 1'b1;
    step();
    chk_reset_vals("t5a");
    rst = 1'b0; cyc = 1;
    measure_release("t5a");

    // T5b: rst during FAULT
    pll_locked = 1'b0; restart = 1'b1;
    step();
    restart = 1'b0;
    wait_sig("t5b_reach_fault", 2, 1'b1, 400, n);
    chk("t5b_fault_prst", pll_rst, 1);
    rst = 1'b1;
    step();
    chk_reset_vals("t5b");
    rst = 1'b0; pll_locked = 1'b1; cyc = 1;
    measure_release("t5b");

    // T6: rst and restart together while running
    rst = 1'b1; restart = 1'b1;
    step();
    chk_reset_vals("t6");
    rst = 1'b0; restart = 1'b0; cyc = 1;
    measure_release("t6");

    // Randomized phase against the model
    total = 0;
    while (total < 15000 && n_mis <= 100) begin
      n = $urandom_range(0, 99);
      if (n < 3) begin
        rst = 1'b1;
        len = $urandom_range(1, 3);
      end else if (n < 8) begin
        restart = 1'b1;
        len = 1;
      end else begin
        pll_locked = ($urandom_range(0, 3) != 0);
        len = pll_locked ? $urandom_range(1, 400) : $urandom_range(1, 150);
      end
      repeat (len) step();
      total += len;
      rst = 1'b0;
      restart = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
